vga_text_ctrl: RTL and testbench

VGA_TEXT_CTRL -- requirements
Module: vga_text_ctrl

---
 rtl/vga_text_ctrl_if.sv | 19 +
 rtl/vga_text_ctrl.sv | 170 +++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_ctrl_if.sv
// Memory-side bus of the text controller: text RAM read port and font ROM
// read port. The controller is the master; the memories answer on the slave side.
interface vga_text_ctrl_if;
  logic [10:0] txt_addr;
  logic [7:0]  txt_rdata;
  logic [10:0] rom_addr;
  logic [6:0]  rom_font_type;
  logic        rom_rdata;

  modport master (
    output txt_addr, rom_addr, rom_font_type,
    input  txt_rdata, rom_rdata
  );

  modport slave (
    input  txt_addr, rom_addr, rom_font_type,
    output txt_rdata, rom_rdata
  );
endinterface

// File: rtl/vga_text_ctrl.sv
// VGA text-mode controller: 40x30 grid of 16x16 character cells, blinking
// block cursor, 3-stage pipeline (counters -> text fetch -> glyph fetch ->
// output). Memory read data is expected by the pix_ce edge following the
// address change. Counters are 10 bits wide, which covers the default timing.
module vga_text_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_ce,
  input  logic [11:0]            fg_color,
  input  logic [11:0]            bg_color,
  input  logic                   cursor_en,
  input  logic [5:0]             cursor_col,
  input  logic [4:0]             cursor_row,
  vga_text_ctrl_if.master        mem,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic [11:0]            vga_rgb,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // stage 0: counters and derived flags
  logic [9:0]    h_cnt, v_cnt, h_nxt, v_nxt;
  logic          h_wrap, v_wrap;
  logic          act0, hs0, vs0, hit0;
  logic [10:0]   addr_nxt;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // stage 1: text data captured
  logic [7:0]    s1_char;
  logic [3:0]    s1_row, s1_col;
  logic          s1_act, s1_hs, s1_vs, s1_hit;

  // stage 2: glyph pixel captured
  logic          s2_pix, s2_act, s2_hs, s2_vs, s2_hit;
  logic          pix3;

  // Next counter values, sync/active flags and cursor match for the current pixel
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
    end
    act0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs0  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    hit0 = (h_cnt[9:4] == cursor_col) && (v_cnt[8:4] == cursor_row);
    // Text address is registered together with the counters, so it is
    // computed from the next counter values and always matches h_cnt/v_cnt.
    addr_nxt = 11'(v_nxt[8:4]) * 11'd40 + 11'(h_nxt[9:4]);
  end

  // Pixel/line counters, text address, frame pulse and blink timer
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      mem.txt_addr <= '0;
      frame_start  <= 1'b0;
      blink_cnt    <= '0;
      blink_on     <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        h_cnt        <= h_nxt;
        v_cnt        <= v_nxt;
        mem.txt_addr <= addr_nxt;
        if (h_wrap && v_wrap) begin
          frame_start <= 1'b1;
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      end
    end
  end

  // Stage 1: capture character code alongside the pixel's control bits
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_char <= '0;
      s1_row  <= '0;
      s1_col  <= '0;
      s1_act  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_hit  <= 1'b0;
    end else if (pix_ce) begin
      s1_char <= mem.txt_rdata;
      s1_row  <= v_cnt[3:0];
      s1_col  <= h_cnt[3:0];
      s1_act  <= act0;
      s1_hs   <= hs0;
      s1_vs   <= vs0;
      s1_hit  <= hit0;
    end
  end

  // Glyph lookup: printable ASCII maps to glyph index char-0x20, anything else to blank
  always_comb begin
    mem.rom_font_type = '0;
    if (!s1_char[7] && (s1_char[6:5] != 2'b00)) begin
      mem.rom_font_type = s1_char[6:0] - 7'h20;
    end
    mem.rom_addr = {3'b000, s1_row, s1_col};
  end

  // Stage 2: capture glyph pixel and carry control bits
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_pix <= 1'b0;
      s2_act <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_hit <= 1'b0;
    end else if (pix_ce) begin
      s2_pix <= mem.rom_rdata;
      s2_act <= s1_act;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_hit <= s1_hit;
    end
  end

  assign pix3 = s2_pix ^ (s2_hit && cursor_en && blink_on);

  // Stage 3: registered colour and active-low syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rgb <= '0;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else if (pix_ce) begin
      vga_rgb <= s2_act ? (pix3 ? fg_color : bg_color) : '0;
      vga_hs  <= ~s2_hs;
      vga_vs  <= ~s2_vs;
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Testbench for vga_text_ctrl with reduced timing (64x32 pixel frame,
// 48x24 visible, 2-frame blink). Stimulus pushes the expected output of each
// pixel entering the counters into a queue; a monitor pops one entry per
// pix_ce and holds the last entry on idle clocks.
module tb_vga_text_ctrl;

  localparam int HA = 48, HF = 4, HS = 8, HB = 4;
  localparam int VA = 24, VF = 2, VS = 2, VB = 4;
  localparam int BF = 2;
  localparam int HT = HA + HF + HS + HB;   // 64
  localparam int VT = VA + VF + VS + VB;   // 32

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic [11:0] fg_color = 12'hABC;
  logic [11:0] bg_color = 12'h123;
  logic        cursor_en = 1'b0;
  logic [5:0]  cursor_col = 6'd2;
  logic [4:0]  cursor_row = 5'd1;
  logic        vga_hs, vga_vs, frame_start;
  logic [11:0] vga_rgb;

  vga_text_ctrl_if mem_if();

  logic [7:0] ram [0:2047];

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   bx = 0, by = 0, frame_no = 0;
  logic chk_map = 1'b0;

  vga_text_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .mem        (mem_if),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_rgb    (vga_rgb),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Glyph set: 0x21 ('A') lights pixels right of the diagonal, 0x5F (DEL) is solid
  function automatic logic glyph(input logic [6:0] t, input logic [10:0] a);
    if (a[10:8] != 3'b000) return 1'b0;
    if (t == 7'h21) return (a[3:0] > a[7:4]);
    if (t == 7'h5F) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] font_of(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7F) return 7'(ch - 8'h20);
    return 7'h00;
  endfunction

  assign mem_if.txt_rdata = ram[mem_if.txt_addr];
  assign mem_if.rom_rdata = glyph(mem_if.rom_font_type, mem_if.rom_addr);

  function automatic exp_t expect_px(input int x, input int y);
    exp_t e;
    int col, row;
    logic g, hit, act;
    col = x / 16;
    row = y / 16;
    g   = glyph(font_of(ram[row * 40 + col]), {3'b000, 4'(y % 16), 4'(x % 16)});
    act = (x < HA) && (y < VA);
    hit = cursor_en && (col == int'(cursor_col)) && (row == int'(cursor_row))
          && (((frame_no / BF) % 2) == 0);
    e.rgb = act ? ((g ^ hit) ? fg_color : bg_color) : 12'h000;
    e.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
    e.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t (pixel %0d,%0d frame %0d)",
               name, act, req, $time, bx, by, frame_no);
    end
  endtask

  // Monitor: reset values during reset, one queue entry per pix_ce, hold otherwise
  always @(posedge clk) begin : mon
    logic ce_s, rst_s;
    ce_s  = pix_ce;
    rst_s = rst;
    #1;
    if (rst_s) begin
      q.delete();
      cur = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
      chk("rst_rgb", 32'(vga_rgb), 32'(cur.rgb));
      chk("rst_hs", 32'(vga_hs), 32'(cur.hs));
      chk("rst_vs", 32'(vga_vs), 32'(cur.vs));
      chk("rst_frame_start", 32'(frame_start), 32'd0);
    end else if (ce_s) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
      end else begin
        cur = q.pop_front();
        chk("rgb", 32'(vga_rgb), 32'(cur.rgb));
        chk("hs", 32'(vga_hs), 32'(cur.hs));
        chk("vs", 32'(vga_vs), 32'(cur.vs));
      end
    end else begin
      chk("hold_rgb", 32'(vga_rgb), 32'(cur.rgb));
      chk("hold_hs", 32'(vga_hs), 32'(cur.hs));
      chk("hold_vs", 32'(vga_vs), 32'(cur.vs));
    end
  end

  // One clock of stimulus; on pix_ce the bench pixel advances and its expectation is queued
  task automatic tick(input logic ce);
    int   px, py;
    logic wrap;
    px   = bx;
    py   = by;
    wrap = 1'b0;
    @(negedge clk);
    pix_ce = ce;
    if (ce) begin
      bx++;
      if (bx == HT) begin
        bx = 0;
        by++;
        if (by == VT) begin
          by = 0;
          wrap = 1'b1;
          frame_no++;
        end
      end
      q.push_back(expect_px(bx, by));
    end
    @(posedge clk);
    #1;
    chk("frame_start", 32'(frame_start), 32'(wrap));
    if (ce) begin
      chk("txt_addr", 32'(mem_if.txt_addr), 32'((by / 16) * 40 + bx / 16));
      chk("font_type", 32'(mem_if.rom_font_type), 32'(font_of(ram[(py / 16) * 40 + px / 16])));
      chk("rom_addr", 32'(mem_if.rom_addr), 32'({3'b000, 4'(py % 16), 4'(px % 16)}));
      if (chk_map && bx == 37 && by == 18)
        chk("map_txt_addr_37_18", 32'(mem_if.txt_addr), 32'd42);
      if (chk_map && px == 37 && py == 18) begin
        chk("map_font_37_18", 32'(mem_if.rom_font_type), 32'h21);
        chk("map_rom_addr_37_18", 32'(mem_if.rom_addr), 32'h025);
      end
      if (chk_map && px == 20 && py == 3)
        chk("invalid_char_font", 32'(mem_if.rom_font_type), 32'd0);
    end
  endtask

  // Hold reset for n clocks with pix_ce high, then restart the bench model at (0,0)
  task automatic do_reset(input int n);
    @(negedge clk);
    rst    = 1'b1;
    pix_ce = 1'b1;
    repeat (n) @(negedge clk);
    chk("rst_txt_addr", 32'(mem_if.txt_addr), 32'd0);
    chk("rst_rom_addr", 32'(mem_if.rom_addr), 32'd0);
    chk("rst_font_type", 32'(mem_if.rom_font_type), 32'd0);
    rst      = 1'b0;
    pix_ce   = 1'b0;
    bx       = 0;
    by       = 0;
    frame_no = 0;
    q.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
    q.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
    q.push_back(expect_px(0, 0));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'h20;
    ram[0]  = 8'h41;   // 'A'
    ram[1]  = 8'h0A;   // non-printable -> blank
    ram[2]  = 8'h7F;   // solid glyph
    ram[41] = 8'h41;
    ram[42] = 8'h41;

    // Phase 1: continuous pix_ce, cursor off, address mapping checks
    chk_map = 1'b1;
    do_reset(3);
    repeat (HT * VT + HT) tick(1'b1);

    // Phase 2: cursor on a blank cell (2,1), blink over five frames
    chk_map = 1'b0;
    ram[42] = 8'h20;
    cursor_en = 1'b1;
    do_reset(3);
    repeat (5 * HT * VT) tick(1'b1);

    // Phase 3: pix_ce every 4th clock for a full frame
    do_reset(3);
    repeat (HT * VT + 200) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
    end

    // Phase 4: reset mid-frame at pixel (30,20), then run past the next frame start
    for (int i = 0; i < HT * VT && !(bx == 30 && by == 20); i++) tick(1'b1);
    do_reset(3);
    tick(1'b1);
    chk("restart_txt_addr", 32'(mem_if.txt_addr), 32'd0);
    repeat (HT * VT + 16) tick(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
